// File: rtl/coprocessor_io_master.sv
// Avalon-MM master issuing single-word reads/writes on behalf of the coprocessor.
// One command in flight at a time; every command returns one response, possibly a timeout error.
module coprocessor_io_master #(
    parameter int unsigned ADDR_W  = 15,
    parameter bit          USE_RDV = 1'b1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,

    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,

    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ACCESS    = 2'd1;
    localparam logic [1:0] WAIT_DATA = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    // Abort fires on the edge where the stall count would reach TIMEOUT.
    localparam logic [9:0] TCNT_LAST = 10'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [9:0]        tcnt_q, tcnt_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        read_d      = read_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d     = ACCESS;
                    tcnt_d      = '0;
                    read_d      = !cmd_write;
                    write_d     = cmd_write;
                    addr_d      = {cmd_addr, 2'b00};
                    wdata_d     = cmd_wdata;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b0;
                end
            end

            ACCESS: begin
                if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    tcnt_d  = '0;
                    if (write_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else if (!USE_RDV) begin
                        rsp_rdata_d = avm_readdata;
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end else if (tcnt_q == TCNT_LAST) begin
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 10'd1;
                end
            end

            WAIT_DATA: begin
                // Data arriving on the timeout edge still counts as a completion.
                if (avm_readdatavalid) begin
                    rsp_rdata_d = avm_readdata;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else if (tcnt_q == TCNT_LAST) begin
                    rsp_error_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 10'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            read_q      <= read_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign cmd_ready      = (state_q == IDLE) && !reset;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_error      = rsp_error_q;
    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_coprocessor_io_master.sv
// Directed bench for coprocessor_io_master: instance A uses readdatavalid, instance B does not,
// both with an 8-cycle timeout. Inputs change on the falling edge; outputs are sampled there too.
module tb_coprocessor_io_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_cmd_valid = 1'b0, b_cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [14:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = '0;
    logic        rdv = 1'b0;

    logic        a_cmd_ready, a_rsp_valid, a_rsp_error, a_read, a_write;
    logic [31:0] a_rsp_rdata, a_writedata;
    logic [16:0] a_address;
    logic [3:0]  a_be;
    logic        b_cmd_ready, b_rsp_valid, b_rsp_error, b_read, b_write;
    logic [31:0] b_rsp_rdata, b_writedata;
    logic [16:0] b_address;
    logic [3:0]  b_be;

    coprocessor_io_master #(.ADDR_W(15), .USE_RDV(1'b1), .TIMEOUT(8)) dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_error(a_rsp_error),
        .avm_address(a_address), .avm_read(a_read), .avm_write(a_write),
        .avm_writedata(a_writedata), .avm_byteenable(a_be), .avm_waitrequest(waitrequest),
        .avm_readdata(readdata), .avm_readdatavalid(rdv)
    );

    coprocessor_io_master #(.ADDR_W(15), .USE_RDV(1'b0), .TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error),
        .avm_address(b_address), .avm_read(b_read), .avm_write(b_write),
        .avm_writedata(b_writedata), .avm_byteenable(b_be), .avm_waitrequest(waitrequest),
        .avm_readdata(readdata), .avm_readdatavalid(rdv)
    );

    always #5 clk = ~clk;

    bit          sel_b = 1'b0;
    logic        s_ready, s_rsp_valid, s_rsp_error, s_read, s_write;
    logic [31:0] s_rsp_rdata, s_writedata;
    logic [16:0] s_address;
    logic [3:0]  s_be;

    always_comb begin
        s_ready     = sel_b ? b_cmd_ready : a_cmd_ready;
        s_rsp_valid = sel_b ? b_rsp_valid : a_rsp_valid;
        s_rsp_error = sel_b ? b_rsp_error : a_rsp_error;
        s_rsp_rdata = sel_b ? b_rsp_rdata : a_rsp_rdata;
        s_read      = sel_b ? b_read : a_read;
        s_write     = sel_b ? b_write : a_write;
        s_writedata = sel_b ? b_writedata : a_writedata;
        s_address   = sel_b ? b_address : a_address;
        s_be        = sel_b ? b_be : a_be;
    end

    typedef struct {
        bit          use_b;
        bit          write;
        logic [14:0] addr;
        logic [31:0] wdata;
        int          stall;      // waitrequest high for edges 1..stall after acceptance
        int          rdv_at;     // edge index carrying readdatavalid on A (0 = never)
        logic [31:0] rdata;
        logic [16:0] exp_addr;
        int          exp_strobe; // cycles the strobe is seen high
        int          exp_rsp_k;  // falling edge (counted from acceptance) showing rsp_valid
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    localparam logic [31:0] JUNK = 32'hBAD0BAD0;

    int checks = 0;
    int failures = 0;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  k;
        int  strobes;
        bit  got;
        bit  addr_moved;
        bit  wrong_strobe;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        sel_b       = v.use_b;
        cmd_write   = v.write;
        cmd_addr    = v.addr;
        cmd_wdata   = v.wdata;
        waitrequest = 1'b0;
        rdv         = 1'b0;
        readdata    = JUNK;
        check({tag, " ready_idle"}, 32'(s_ready), 32'd1);
        if (v.use_b) b_cmd_valid = 1'b1;
        else a_cmd_valid = 1'b1;
        @(negedge clk);
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
        check({tag, " address"}, 32'(s_address), 32'(v.exp_addr));
        check({tag, " byteenable"}, 32'(s_be), 32'hF);
        check({tag, " writedata"}, s_writedata, v.wdata);
        check({tag, " ready_busy"}, 32'(s_ready), 32'd0);
        k = 1;
        strobes = 0;
        got = 1'b0;
        addr_moved = 1'b0;
        wrong_strobe = 1'b0;
        while (!got && k < 30) begin
            if (s_rsp_valid) begin
                got = 1'b1;
                check({tag, " rsp_latency"}, 32'(k), 32'(v.exp_rsp_k));
                check({tag, " rsp_rdata"}, s_rsp_rdata, v.exp_rdata);
                check({tag, " rsp_error"}, 32'(s_rsp_error), 32'(v.exp_err));
            end else begin
                if (v.write ? s_write : s_read) begin
                    strobes++;
                    if (s_address !== v.exp_addr) addr_moved = 1'b1;
                end
                if (v.write ? s_read : s_write) wrong_strobe = 1'b1;
                waitrequest = (k <= v.stall);
                if (v.use_b) begin
                    rdv      = 1'b0;
                    readdata = (k > v.stall) ? v.rdata : JUNK;
                end else begin
                    // A stray readdatavalid during ACCESS must be ignored.
                    rdv      = (k == 1) || (v.rdv_at != 0 && k == v.rdv_at);
                    readdata = (v.rdv_at != 0 && k == v.rdv_at) ? v.rdata : JUNK;
                end
                @(negedge clk);
                k++;
            end
        end
        waitrequest = 1'b0;
        rdv = 1'b0;
        check({tag, " rsp_seen"}, 32'(got), 32'd1);
        check({tag, " strobe_cycles"}, 32'(strobes), 32'(v.exp_strobe));
        check({tag, " addr_stable"}, 32'(addr_moved), 32'd0);
        check({tag, " other_strobe"}, 32'(wrong_strobe), 32'd0);
        @(negedge clk);
        check({tag, " rsp_one_cycle"}, 32'(s_rsp_valid), 32'd0);
        check({tag, " ready_again"}, 32'(s_ready), 32'd1);
    endtask

    task automatic check_a_reset_values(input string tag);
        check({tag, " strobes_rsp"}, 32'({a_read, a_write, a_rsp_valid, a_rsp_error}), 32'd0);
        check({tag, " address"}, 32'(a_address), 32'd0);
        check({tag, " writedata"}, a_writedata, 32'd0);
        check({tag, " rsp_rdata"}, a_rsp_rdata, 32'd0);
    endtask

    initial begin
        int  n_rsp;
        int  wait_cnt;
        bit  rsp_seen;

        vecs[0] = '{1'b0, 1'b1, 15'h0005, 32'hDEADBEEF, 0, 0, 32'h0,
                    17'h00014, 1, 2, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 15'h0123, 32'h0, 3, 6, 32'h12345678,
                    17'h0048C, 4, 7, 32'h12345678, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 15'h7FFF, 32'h0, 2, 0, 32'hCAFEF00D,
                    17'h1FFFC, 3, 4, 32'hCAFEF00D, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 15'h0010, 32'h00001111, 8, 0, 32'h0,
                    17'h00040, 8, 9, 32'h0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 15'h0001, 32'h0, 0, 2, 32'h0000A5A5,
                    17'h00004, 1, 3, 32'h0000A5A5, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 15'h0002, 32'h0, 7, 9, 32'h5A5A0001,
                    17'h00008, 8, 10, 32'h5A5A0001, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 15'h0003, 32'h0, 0, 0, 32'h77777777,
                    17'h0000C, 1, 10, 32'h0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 15'h0004, 32'h0, 0, 9, 32'h89ABCDEF,
                    17'h00010, 1, 10, 32'h89ABCDEF, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 15'h0100, 32'h0, 8, 0, 32'h13579BDF,
                    17'h00400, 8, 9, 32'h0, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 15'h0000, 32'hFFFFFFFF, 1, 0, 32'h0,
                    17'h00000, 2, 3, 32'h0, 1'b0};

        repeat (2) @(negedge clk);
        check("reset ready_low_a", 32'(a_cmd_ready), 32'd0);
        check("reset ready_low_b", 32'(b_cmd_ready), 32'd0);
        check_a_reset_values("reset");
        reset = 1'b0;
        #1;
        check("reset ready_high", 32'(a_cmd_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back: cmd_valid held across three writes on A.
        sel_b = 1'b0;
        n_rsp = 0;
        @(negedge clk);
        cmd_write = 1'b1;
        cmd_addr = 15'd1;
        cmd_wdata = 32'h100;
        a_cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cnt = 0;
            while (!a_cmd_ready && wait_cnt < 20) begin
                @(negedge clk);
                wait_cnt++;
            end
            check($sformatf("b2b%0d accept_wait", i), 32'(a_cmd_ready), 32'd1);
            @(negedge clk);
            if (i == 2) a_cmd_valid = 1'b0;
            check($sformatf("b2b%0d ready_busy", i), 32'(a_cmd_ready), 32'd0);
            check($sformatf("b2b%0d address", i), 32'(a_address), 32'((i + 1) * 4));
            check($sformatf("b2b%0d writedata", i), a_writedata, 32'(32'h100 + i));
            wait_cnt = 0;
            while (!a_rsp_valid && wait_cnt < 20) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (a_rsp_valid && !a_rsp_error) n_rsp++;
            cmd_addr = 15'(i + 2);
            cmd_wdata = 32'(32'h100 + i + 1);
        end
        rsp_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (a_rsp_valid || a_write) rsp_seen = 1'b1;
        end
        check("b2b response_count", 32'(n_rsp), 32'd3);
        check("b2b no_extra_txn", 32'(rsp_seen), 32'd0);

        // Reset while waiting for read data, then a late readdatavalid.
        cmd_write = 1'b0;
        cmd_addr = 15'h0009;
        a_cmd_valid = 1'b1;
        @(negedge clk);
        a_cmd_valid = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        check("rst_mid in_wait_data", 32'({a_read, a_cmd_ready}), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_mid ready_in_reset", 32'(a_cmd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp_seen = a_rsp_valid;
        @(negedge clk);
        rdv = 1'b1;
        readdata = 32'hFEEDFACE;
        @(negedge clk);
        rdv = 1'b0;
        readdata = '0;
        repeat (3) begin
            if (a_rsp_valid) rsp_seen = 1'b1;
            @(negedge clk);
        end
        check("rst_mid no_response", 32'(rsp_seen), 32'd0);
        check_a_reset_values("rst_mid");
        check("rst_mid ready", 32'(a_cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
